// File: rtl/cache_mem_if.sv
// cache_mem_if
//   Memory-side interface of the cache controller. Turns one line request
//   from the cache FSM into a single RAM bus transaction. A fill collects
//   the BEATS-byte read burst into one line; a writeback waits for the
//   single write acknowledge. A missing first acknowledge aborts the
//   transaction after TIMEOUT cycles.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_req       transaction request, sampled only while o_busy = 0
//   i_req_rnw   1 = line fill (read), 0 = writeback (write)
//   o_busy      high from the cycle after acceptance through the done cycle
//   o_done      one-cycle completion / abort pulse
//   o_err       one-cycle pulse with o_done on a timeout abort
//   o_line      assembled fill line, byte 0 in [7:0]
//   o_avalid    RAM command strobe, one cycle per transaction
//   o_rnw       RAM direction, stable from o_avalid until o_done
//   i_ack       RAM per-beat valid (read) or write acknowledge
//   i_rdata     RAM read byte, valid with i_ack
//
// State table
//   state   | meaning
//   IDLE    | waiting for a request; i_ack ignored
//   ISSUE   | o_avalid strobe, timeout counter cleared
//   WAIT_RD | collecting read beats, counting beats not cycles
//   WAIT_WR | waiting for the write acknowledge
//   DONE    | o_done (and o_err on abort), counters cleared

module cache_mem_if #(
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic                 i_req_rnw,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [8*BEATS-1:0]   o_line,
  output logic                 o_avalid,
  output logic                 o_rnw,
  input  logic                 i_ack,
  input  logic [7:0]           i_rdata
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_WAIT_WR = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               r_rnw;
  logic [BW-1:0]      r_beat;
  logic [TW-1:0]      r_tmo;
  logic               r_err;
  logic [8*BEATS-1:0] r_line;

  logic w_cap;       // capture a read beat this cycle
  logic w_tmo_run;   // timeout counter is active this cycle
  logic w_tmo_hit;   // this cycle is the last one allowed before abort

  // The timeout only guards the wait for the first acknowledge: once a read
  // beat has landed (r_beat != 0) the burst is allowed to run with gaps.
  always_comb begin
    w_cap     = (r_state == S_WAIT_RD) && i_ack;
    w_tmo_run = ((r_state == S_WAIT_RD) && (r_beat == '0) && !i_ack) ||
                ((r_state == S_WAIT_WR) && !i_ack);
    w_tmo_hit = w_tmo_run && (r_tmo == TMO_LAST);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_state_nxt = r_rnw ? S_WAIT_RD : S_WAIT_WR;
      end
      S_WAIT_RD: begin
        if (w_cap && (r_beat == LAST_BEAT)) w_state_nxt = S_DONE;
        else if (w_tmo_hit)                 w_state_nxt = S_DONE;
      end
      S_WAIT_WR: begin
        if (i_ack || w_tmo_hit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Direction is only latched in IDLE, so it stays put for the whole
  // transaction even if the cache FSM changes i_req_rnw meanwhile.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rnw <= 1'b0;
    end else if ((r_state == S_IDLE) && i_req) begin
      r_rnw <= i_req_rnw;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo <= '0;
    end else if (r_state == S_ISSUE) begin
      r_tmo <= '0;
    end else if (w_tmo_run && !w_tmo_hit) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_err <= 1'b0;
    end else if (w_tmo_hit) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat <= '0;
    end else if (r_state == S_DONE) begin
      r_beat <= '0;
    end else if (w_cap) begin
      r_beat <= r_beat + BW'(1);
    end
  end

  // Bytes land only while in WAIT_RD; stray acks elsewhere never touch the line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line <= '0;
    end else if (w_cap) begin
      for (int k = 0; k < BEATS; k++) begin
        if (r_beat == BW'(k)) r_line[8*k +: 8] <= i_rdata;
      end
    end
  end

  // All outputs decode registered state only, so they are glitch-free with
  // respect to the RAM-side inputs and drop to zero the moment reset asserts.
  always_comb begin
    o_avalid = (r_state == S_ISSUE);
    o_busy   = (r_state != S_IDLE);
    o_done   = (r_state == S_DONE);
    o_err    = (r_state == S_DONE) && r_err;
    o_rnw    = r_rnw;
    o_line   = r_line;
  end

endmodule
